// File: rtl/rsqrt_stream.sv
// Byte-stream to float32 frame assembler feeding an external fixed-latency 1/sqrt FPU,
// with credit-based issue into a result FIFO. Optional define RSQRT_NEG_FLAG_EN adds o_neg.
module rsqrt_stream #(
  parameter int WORDS      = 10,
  parameter int FPU_LAT    = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enb,
  input  logic [7:0]  i_data,
  output logic        o_busy,
  output logic [31:0] o_fpu_a,
  input  logic [31:0] i_fpu_q,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data
`ifdef RSQRT_NEG_FLAG_EN
  ,
  output logic        o_neg
`endif
);

  localparam int WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef RSQRT_NEG_FLAG_EN
  localparam int ENT_W = 33;
`else
  localparam int ENT_W = 32;
`endif
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(WORDS - 1);

  typedef enum logic [1:0] {S_RECV, S_ISSUE, S_DRAIN} state_t;

  state_t           state;
  logic [WI_W-1:0]  recv_word;
  logic [1:0]       recv_byte;
  logic [WI_W-1:0]  word_idx;
  logic [31:0]      frame [WORDS];
  logic [FPU_LAT:0] vld_pipe;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   outstanding;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] wr_entry;
  logic             credit;
  logic             issue;
  logic             wr;
  logic             pop;

  // Every issued word has a reserved FIFO slot, so the write side never checks for full.
  assign outstanding = {1'b0, inflight} + {1'b0, count};
  assign credit      = outstanding < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue       = (state == S_ISSUE) && credit;
  assign wr          = vld_pipe[FPU_LAT];
  assign pop         = o_valid && i_ready;
  assign o_valid     = (count != '0);
  assign o_busy      = (state != S_RECV);
  assign o_data      = o_valid ? mem[rd_ptr][31:0] : 32'h0;

`ifdef RSQRT_NEG_FLAG_EN
  logic [FPU_LAT:0] neg_pipe;

  function automatic logic neg_of(input logic [31:0] w);
    return w[31] && (w[30:0] != 31'h0);
  endfunction

  // Sign flag rides a data-only pipe aligned with vld_pipe.
  always_ff @(posedge i_clk) begin
    neg_pipe <= {neg_pipe[FPU_LAT-1:0], neg_of(frame[word_idx])};
  end

  assign wr_entry = {neg_pipe[FPU_LAT], i_fpu_q};
  assign o_neg    = o_valid && mem[rd_ptr][32];
`else
  assign wr_entry = i_fpu_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_RECV;
      recv_word <= '0;
      recv_byte <= 2'd0;
      word_idx  <= '0;
      o_fpu_a   <= 32'h0;
      vld_pipe  <= '0;
      inflight  <= '0;
    end else begin
      // vld_pipe[0] marks o_fpu_a as a live operand; bit FPU_LAT lines up with i_fpu_q.
      vld_pipe <= {vld_pipe[FPU_LAT-1:0], issue};
      inflight <= inflight + CNT_W'(issue) - CNT_W'(wr);
      case (state)
        S_RECV: begin
          if (i_enb) begin
            recv_byte <= recv_byte + 2'd1;
            if (recv_byte == 2'd3) begin
              if (recv_word == LAST_WORD) begin
                recv_word <= '0;
                state     <= S_ISSUE;
              end else begin
                recv_word <= recv_word + WI_W'(1);
              end
            end
          end
        end
        S_ISSUE: begin
          if (credit) begin
            o_fpu_a <= frame[word_idx];
            if (word_idx == LAST_WORD) begin
              word_idx <= '0;
              state    <= S_DRAIN;
            end else begin
              word_idx <= word_idx + WI_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (inflight == '0) state <= S_RECV;
        end
        default: state <= S_RECV;
      endcase
    end
  end

  // Big-endian lane select: byte 0 of a word lands in bits [31:24].
  always_ff @(posedge i_clk) begin
    if ((state == S_RECV) && i_enb)
      frame[recv_word][{~recv_byte, 3'b000} +: 8] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_rsqrt_stream.sv
// Scoreboard bench for rsqrt_stream: ideal delay-line FPU model, frame-level reference,
// monitor pops expected results whenever o_valid && i_ready.
module tb_rsqrt_stream;
  localparam int WORDS      = 10;
  localparam int FPU_LAT    = 20;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enb = 1'b0;
  logic [7:0]  data = 8'h0;
  logic        busy;
  logic [31:0] fpu_a;
  logic [31:0] fpu_q;
  logic        ovalid;
  logic        ready;
  logic [31:0] odata;
`ifdef RSQRT_NEG_FLAG_EN
  logic        neg;
`endif

  always #5 clk = ~clk;

  rsqrt_stream #(.WORDS(WORDS), .FPU_LAT(FPU_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enb(enb), .i_data(data), .o_busy(busy),
    .o_fpu_a(fpu_a), .i_fpu_q(fpu_q), .o_valid(ovalid), .i_ready(ready),
    .o_data(odata)
`ifdef RSQRT_NEG_FLAG_EN
    , .o_neg(neg)
`endif
  );

  // Ideal 1/sqrt for the values the bench reasons about; other inputs get an arbitrary
  // but deterministic mapping so ordering and loss remain observable.
  function automatic logic [31:0] fpu_ref(input logic [31:0] x);
    case (x)
      32'h3F800000: return 32'h3F800000;
      32'h40800000: return 32'h3F000000;
      32'h3E800000: return 32'h40000000;
      default:      return {x[15:0], x[31:16]} ^ 32'h5F3759DF;
    endcase
  endfunction

  logic [31:0] fpu_pipe [FPU_LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_ref(fpu_a);
    for (int i = 1; i < FPU_LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign fpu_q = fpu_pipe[FPU_LAT-1];

  typedef struct packed {
    logic [31:0] d;
    logic        n;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic rnd_ready = 1'b0;
  logic ready_fix = 1'b1;
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
    end
  end

  logic        hold_v = 1'b0;
  logic [31:0] hold_d = 32'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", {31'h0, ovalid}, 32'h1);
        check("hold_data", odata, hold_d);
      end
      if (ovalid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output actual=%h expected=none", odata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", odata, e.d);
`ifdef RSQRT_NEG_FLAG_EN
          check("neg_flag", {31'h0, neg}, {31'h0, e.n});
`endif
        end
      end
      hold_v = ovalid && !ready;
      hold_d = odata;
    end
  end

  int          a_changes = 0;
  logic [31:0] last_a = 32'h0;
  always @(negedge clk) begin
    if (fpu_a !== last_a) a_changes++;
    last_a = fpu_a;
  end

  logic [31:0] fw [WORDS];

  task automatic send_bytes(input int n);
    for (int b = 0; b < n; b++) begin
      enb  = 1'b1;
      data = fw[b/4][8*(3 - b%4) +: 8];
      @(posedge clk); #1;
    end
    enb = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", exp_q.size(), 32'h0);
  endtask

  task automatic send_frame();
    exp_t e;
    wait_idle();
    send_bytes(4 * WORDS);
    for (int i = 0; i < WORDS; i++) begin
      e.d = fpu_ref(fw[i]);
      e.n = fw[i][31] && (fw[i][30:0] != 31'h0);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < WORDS; i++) fw[i] = $urandom();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, {31'h0, ovalid}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_fpu_a"}, fpu_a, 32'h0);
    check({tag, "_data"}, odata, 32'h0);
  endtask

  initial begin
    int snap;
    #12;
    reset_checks("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // First-result latency with a frame of 1.0
    for (int i = 0; i < WORDS; i++) fw[i] = 32'h3F800000;
    send_frame();
    repeat (FPU_LAT + 1) @(posedge clk);
    #1;
    check("lat_before", {31'h0, ovalid}, 32'h0);
    @(posedge clk); #1;
    check("lat_first", {31'h0, ovalid}, 32'h1);
    check("lat_data", odata, 32'h3F800000);
    wait_drain();

    // Known values and sign-flag corner cases
    rand_frame();
    fw[0] = 32'h40800000;
    fw[1] = 32'h3E800000;
    fw[2] = 32'hBF800000;
    fw[3] = 32'h80000000;
    send_frame();
    wait_drain();

    // Bytes strobed while busy must be dropped
    rand_frame();
    send_frame();
    for (int k = 0; k < 5; k++) begin
      check("busy_in_issue", {31'h0, busy}, 32'h1);
      enb  = 1'b1;
      data = 8'hAA;
      @(posedge clk); #1;
      enb = 1'b0;
      @(posedge clk); #1;
    end
    rand_frame();
    send_frame();
    wait_drain();

    // Backpressure: issue must stop at FIFO_DEPTH outstanding
    ready_fix = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < WORDS; i++) fw[i] = 32'h0BAD0000 + 32'(i * 3);
    snap = a_changes;
    send_frame();
    repeat (50) @(posedge clk);
    #1;
    check("stall_issued", a_changes - snap, FIFO_DEPTH);
    check("stall_valid", {31'h0, ovalid}, 32'h1);
    ready_fix = 1'b1;
    wait_drain();

    // Random backpressure over several frames
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      send_frame();
    end
    wait_drain();
    rnd_ready = 1'b0;
    ready_fix = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset part-way through a frame
    rand_frame();
    wait_idle();
    send_bytes(17);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midframe_rst_valid", {31'h0, ovalid}, 32'h0);
    check("midframe_rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_frame();
    send_frame();
    wait_drain();

    // Reset with three results queued
    ready_fix = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rand_frame();
    send_frame();
    repeat (FPU_LAT + 4) @(posedge clk);
    #1;
    check("queued_valid", {31'h0, ovalid}, 32'h1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    reset_checks("queued_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rand_frame();
    send_frame();
    wait_drain();

    repeat (30) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'h0);
    check("final_no_valid", {31'h0, ovalid}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsqrt_stream.md
RSQRT_STREAM -- requirements
Module: rsqrt_stream

Interface
REQ-001 SHALL have parameter WORDS, default 10, meaning float32 words per frame (frame = 4*WORDS bytes).
REQ-002 SHALL have parameter FPU_LAT, default 20, meaning fixed external FPU pipeline latency in cycles.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning result FIFO entries (power of two, >=2).
REQ-004 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_enb  input  1  input byte strobe.
REQ-007 SHALL have port i_data  input  8  input byte.
REQ-008 SHALL have port o_busy  output  1  high when i_enb is ignored (not in S_RECV).
REQ-009 SHALL have port o_fpu_a  output  32  registered operand to the external 1/sqrt FPU.
REQ-010 SHALL have port i_fpu_q  input  32  FPU result, valid FPU_LAT cycles after the operand.
REQ-011 SHALL have port o_valid  output  1  o_data holds a result.
REQ-012 SHALL have port i_ready  input  1  sink accepts result when o_valid and i_ready are both high.
REQ-013 SHALL have port o_data  output  32  result word, FIFO head.

Function
REQ-014 SHALL implement states S_RECV, S_ISSUE, S_DRAIN.
REQ-015 S_RECV SHALL store each byte with i_enb high and advance a byte index; on the 4*WORDS-th byte it SHALL clear the index and go to S_ISSUE.
REQ-016 Words SHALL assemble big-endian: byte 4k -> bits [31:24], byte 4k+3 -> bits [7:0].
REQ-017 i_enb SHALL be ignored in S_ISSUE/S_DRAIN; those bytes are dropped, not buffered.
REQ-018 S_ISSUE SHALL issue one word per cycle to o_fpu_a, in order, when credit is available.
REQ-019 Credit SHALL be available when in-flight count plus FIFO occupancy is less than FIFO_DEPTH; otherwise the issue stalls and o_fpu_a holds its value.
REQ-020 A FPU_LAT-deep valid shift register SHALL tag issued words; a tagged i_fpu_q SHALL be written to the FIFO in the cycle it emerges, and can never overflow the FIFO.
REQ-021 After the last word is issued the FSM SHALL enter S_DRAIN, and SHALL return to S_RECV once in-flight count is zero; the FIFO MAY still hold results.
REQ-022 With i_ready high and no stalls, o_valid for word k SHALL first assert FPU_LAT+2+k cycles after the last frame byte is accepted.
REQ-023 FIFO SHALL support simultaneous write and pop in one cycle with occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-024 o_data/o_valid SHALL hold stable while o_valid is high and i_ready is low.
REQ-025 Results SHALL leave in issue order with none lost or duplicated.

Reset
REQ-026 i_rst_n low SHALL immediately force S_RECV, byte index 0, in-flight tags 0, FIFO empty, o_valid 0, o_busy 0, o_fpu_a 0, o_data 0.
REQ-027 Reset mid-frame or mid-issue SHALL discard all partial bytes, in-flight results and queued results; the first frame after release starts at byte 0.

Configuration
REQ-028 Macro RSQRT_NEG_FLAG_EN SHALL add output o_neg (1 bit), aligned with o_data/o_valid, high when the source word had bit 31 set and bits [30:0] nonzero.
REQ-029 Without RSQRT_NEG_FLAG_EN, port o_neg and its FIFO bit SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Frame of 10 words of 0x3F800000 (1.0), ideal FPU model, i_ready=1 -> ten outputs 0x3F800000, first at FPU_LAT+2 cycles after the last byte.
REQ-031 Words 0x40800000 (4.0) then 0x3E800000 (0.25) (WORDS=2) -> outputs 0x3F000000 then 0x40000000 in order.
REQ-032 i_ready=0 for 50 cycles during a 10-word frame -> issue stalls at 8 outstanding, no loss, o_data stable; on release all 10 outputs arrive in order.
REQ-033 i_enb pulses during S_ISSUE with byte 0xAA -> o_busy=1, the bytes are ignored, and the next frame is assembled correctly.
REQ-034 i_rst_n low after 17 bytes, and again with 3 results queued -> o_valid=0 at once, FIFO empty; a following clean frame gives correct results.
REQ-035 With RSQRT_NEG_FLAG_EN, input 0xBF800000 -> o_neg=1 with its result; input 0x80000000 -> o_neg=0.
